// File: rtl/button_event_scheduler_pkg.sv
// Shared event codes, tracker state codes and sizing helpers for the button event scheduler.
package button_event_scheduler_pkg;

    typedef logic [1:0] ev_code_t;

    localparam ev_code_t EV_NONE    = 2'd0;
    localparam ev_code_t EV_PRESS   = 2'd1;
    localparam ev_code_t EV_REPEAT  = 2'd2;
    localparam ev_code_t EV_RELEASE = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Index width for n items; a single item still needs one bit.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_hold_tracker.sv
// One button: edge detect, PRESS/REPEAT/RELEASE FSM with hold counter, and a one-deep pending slot.
module button_hold_tracker
    import button_event_scheduler_pkg::*;
#(
    parameter int unsigned REPEAT_WAIT   = 128,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic     i_clock,
    input  logic     i_reset,
    input  logic     i_level,
    input  logic     i_tick,
    input  logic     i_grant,
    output logic     o_pending_c,
    output ev_code_t o_event,
    output logic     o_overflow_c
);

    localparam int unsigned CNT_MAX = max_u(REPEAT_WAIT, REPEAT_PERIOD);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic             prev_q, prev_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ev_code_t         slot_q, slot_d;
    ev_code_t         new_ev;
    logic             rise, fall;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            prev_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            slot_q  <= EV_NONE;
        end else begin
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
        end
    end

    // Hold FSM; a release beats a tick landing in the same cycle.
    always_comb begin : hold_fsm
        prev_d  = i_level;
        state_d = state_q;
        cnt_d   = cnt_q;
        new_ev  = EV_NONE;
        rise    = i_level & ~prev_q;
        fall    = ~i_level & prev_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    new_ev  = EV_PRESS;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fall) begin
                    new_ev  = EV_RELEASE;
                    state_d = ST_IDLE;
                end else if (i_tick) begin
                    if (cnt_q == CNT_W'(REPEAT_WAIT - 1)) begin
                        new_ev  = EV_REPEAT;
                        cnt_d   = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    new_ev  = EV_RELEASE;
                    state_d = ST_IDLE;
                end else if (i_tick) begin
                    if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                        new_ev = EV_REPEAT;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending slot: PRESS/RELEASE always win, a REPEAT only replaces a stale REPEAT.
    always_comb begin : slot_update
        slot_d       = slot_q;
        o_overflow_c = 1'b0;
        if (new_ev != EV_NONE) begin
            if ((slot_q == EV_NONE) || i_grant) begin
                slot_d = new_ev;
            end else begin
                o_overflow_c = 1'b1;
                if ((new_ev != EV_REPEAT) || (slot_q == EV_REPEAT)) begin
                    slot_d = new_ev;
                end
            end
        end else if (i_grant) begin
            slot_d = EV_NONE;
        end
    end

    assign o_pending_c = (slot_q != EV_NONE);
    assign o_event     = slot_q;

endmodule

// File: rtl/button_event_scheduler.sv
// Merges per-button PRESS/REPEAT/RELEASE events into one valid/ready stream with round-robin
// arbitration, a shared hold-timing tick and a sticky overflow flag.
module button_event_scheduler
    import button_event_scheduler_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS   = 4,
    parameter int unsigned TICK_SCALE    = 15,
    parameter int unsigned REPEAT_WAIT   = 128,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic [NUM_BUTTONS-1:0]             i_buttons,
    input  logic                               i_ready,
    output logic                               o_valid,
    output logic [bits_for(NUM_BUTTONS)-1:0]   o_button_id,
    output logic [1:0]                         o_event,
    output logic                               o_overflow,
    input  logic                               i_clear_overflow
);

    localparam int unsigned ID_W = bits_for(NUM_BUTTONS);

    logic [TICK_SCALE-1:0]  tick_cnt_q, tick_cnt_d;
    logic                   tick_c;
    logic [NUM_BUTTONS-1:0] pending_c;
    logic [NUM_BUTTONS-1:0] ovf_pulse_c;
    logic [NUM_BUTTONS-1:0] grant_c;
    ev_code_t               slot_ev [NUM_BUTTONS];

    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic                   valid_q, valid_d;
    logic [ID_W-1:0]        id_q, id_d;
    ev_code_t               ev_q, ev_d;
    logic                   ovf_q, ovf_d;

    logic                   found;
    logic [ID_W-1:0]        sel;
    logic [ID_W:0]          sum;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_trk
        button_hold_tracker #(
            .REPEAT_WAIT   (REPEAT_WAIT),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_trk (
            .i_clock      (i_clock),
            .i_reset      (i_reset),
            .i_level      (i_buttons[g]),
            .i_tick       (tick_c),
            .i_grant      (grant_c[g]),
            .o_pending_c  (pending_c[g]),
            .o_event      (slot_ev[g]),
            .o_overflow_c (ovf_pulse_c[g])
        );
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt_q <= '0;
            ptr_q      <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            ev_q       <= EV_NONE;
            ovf_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            ev_q       <= ev_d;
            ovf_q      <= ovf_d;
        end
    end

    // Free-running prescaler; tick fires in the cycle the counter rolls over.
    assign tick_c = &tick_cnt_q;

    // A fresh loss outranks a same-cycle clear.
    always_comb begin : tick_and_overflow
        tick_cnt_d = tick_cnt_q + TICK_SCALE'(1);
        ovf_d      = (ovf_q & ~i_clear_overflow) | (|ovf_pulse_c);
    end

    // Round-robin pick of the first pending slot at or after the pointer.
    always_comb begin : arbiter
        valid_d = valid_q;
        id_d    = id_q;
        ev_d    = ev_q;
        ptr_d   = ptr_q;
        grant_c = '0;
        found   = 1'b0;
        sel     = '0;
        sum     = '0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (sum >= (ID_W + 1)'(NUM_BUTTONS)) begin
                sum = sum - (ID_W + 1)'(NUM_BUTTONS);
            end
            if (!found && pending_c[ID_W'(sum)]) begin
                found = 1'b1;
                sel   = ID_W'(sum);
            end
        end
        if (!valid_q || i_ready) begin
            valid_d = found;
            if (found) begin
                id_d         = sel;
                ev_d         = slot_ev[sel];
                grant_c[sel] = 1'b1;
                ptr_d        = (sel == ID_W'(NUM_BUTTONS - 1)) ? '0 : sel + ID_W'(1);
            end
        end
    end

    assign o_valid     = valid_q;
    assign o_button_id = id_q;
    assign o_event     = ev_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: cycle tables for tap/arbitration plus a scoreboard for timed sequences.
module tb_button_event_scheduler;

    localparam logic [1:0] P = 2'd1;
    localparam logic [1:0] R = 2'd2;
    localparam logic [1:0] L = 2'd3;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       rdy;
    logic       clr;
    logic       valid;
    logic [1:0] id;
    logic [1:0] ev;
    logic       ovf;

    typedef struct {
        logic [3:0] btn;
        logic       rdy;
        logic       clr;
        logic       valid;
        logic [1:0] id;
        logic [1:0] ev;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [1:0] ev;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   ev_cyc[$];
    int   checks;
    int   failures;
    int   cyc;
    bit   mon_en;

    button_event_scheduler #(
        .NUM_BUTTONS   (4),
        .TICK_SCALE    (2),
        .REPEAT_WAIT   (4),
        .REPEAT_PERIOD (2)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_buttons        (btn),
        .i_ready          (rdy),
        .o_valid          (valid),
        .o_button_id      (id),
        .o_event          (ev),
        .o_overflow       (ovf),
        .i_clear_overflow (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic v, input logic [1:0] i, input logic [1:0] e,
                                         input logic o);
        return 32'({v, i, e, o});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // One clock: scoreboard sample at negedge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (mon_en && valid === 1'b1 && rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got id=%0d ev=%0d want nothing", id, ev);
            end else begin
                e = exp_q.pop_front();
                chk("sb_event", 32'({id, ev}), 32'({e.id, e.ev}));
                ev_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_ev(input logic [1:0] i, input logic [1:0] e);
        exp_t x;
        x.id = i;
        x.ev = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_drain(input string name, input int max_cyc, input bit toggle);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            if (toggle) rdy = ~rdy;
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d events outstanding after %0d cycles, want 0", name, exp_q.size(), max_cyc);
            exp_q.delete();
        end
    endtask

    function automatic void add(input logic [3:0] b, input logic v, input logic [1:0] i,
                                input logic [1:0] e);
        vec_t t;
        t.btn   = b;
        t.rdy   = 1'b1;
        t.clr   = 1'b0;
        t.valid = v;
        t.id    = i;
        t.ev    = e;
        t.ovf   = 1'b0;
        vecs.push_back(t);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [31:0] held;
        int gap;
        rst = 1'b1; btn = '0; rdy = 1'b1; clr = 1'b0;
        mon_en = 1'b0; checks = 0; failures = 0; cyc = 0; bad = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", pack(valid, id, ev, ovf), pack(1'b0, 2'd0, 2'd0, 1'b0));
        rst = 1'b0;

        // Two simultaneous bursts, then a short tap on button 1.
        add(4'hF, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(4'hF, 1, 2'(k), P);
        add(4'h0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(4'h0, 1, 2'(k), L);
        add(4'hF, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(4'hF, 1, 2'(k), P);
        add(4'h0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(4'h0, 1, 2'(k), L);
        add(4'h0, 0, 0, 0);
        add(4'h2, 0, 0, 0);
        add(4'h2, 1, 2'd1, P);
        for (int k = 0; k < 8; k++) add(4'h2, 0, 0, 0);
        add(4'h0, 0, 0, 0);
        add(4'h0, 1, 2'd1, L);
        add(4'h0, 0, 0, 0);

        foreach (vecs[i]) begin
            btn = vecs[i].btn;
            rdy = vecs[i].rdy;
            clr = vecs[i].clr;
            cycle();
            if (vecs[i].valid)
                chk($sformatf("vec%0d", i), pack(valid, id, ev, ovf),
                    pack(vecs[i].valid, vecs[i].id, vecs[i].ev, vecs[i].ovf));
            else
                chk($sformatf("vec%0d_idle", i), 32'({valid, ovf}), 32'({1'b0, vecs[i].ovf}));
        end

        // Long hold on button 0: PRESS, six REPEATs, RELEASE.
        mon_en = 1'b1;
        ev_cyc.delete();
        expect_ev(2'd0, P);
        for (int k = 0; k < 6; k++) expect_ev(2'd0, R);
        expect_ev(2'd0, L);
        btn = 4'h1;
        repeat (58) cycle();
        btn = 4'h0;
        wait_drain("hold_drain", 10, 1'b0);
        chk("hold_event_count", 32'(ev_cyc.size()), 32'd8);
        if (ev_cyc.size() == 8) begin
            gap = ev_cyc[1] - ev_cyc[0];
            chk("hold_first_repeat_window", 32'((gap >= 13) && (gap <= 16)), 32'd1);
            for (int k = 2; k < 7; k++)
                chk($sformatf("hold_repeat_gap%0d", k), 32'(ev_cyc[k] - ev_cyc[k-1]), 32'd8);
        end

        // Backpressure on button 2: output holds PRESS while repeats collide in the slot.
        mon_en = 1'b0;
        rdy = 1'b0;
        btn = 4'h4;
        repeat (3) cycle();
        chk("bp_first", pack(valid, id, ev, ovf), pack(1'b1, 2'd2, P, 1'b0));
        held = 32'({valid, id, ev});
        repeat (37) begin
            cycle();
            if (32'({valid, id, ev}) !== held) bad++;
        end
        btn = 4'h0;
        repeat (3) begin
            cycle();
            if (32'({valid, id, ev}) !== held) bad++;
        end
        chk("bp_unstable_cycles", 32'(bad), 32'd0);
        chk("bp_overflow", 32'(ovf), 32'd1);
        rdy = 1'b1;
        mon_en = 1'b1;
        expect_ev(2'd2, P);
        expect_ev(2'd2, L);
        wait_drain("bp_drain", 6, 1'b0);
        chk("bp_idle_after", 32'(valid), 32'd0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("bp_clear", 32'(ovf), 32'd0);

        // Overwrite of a pending PRESS in the same cycle as a clear keeps the flag set.
        mon_en = 1'b0;
        rdy = 1'b0;
        btn = 4'h8;
        repeat (3) cycle();
        chk("sc_held_out", pack(valid, id, ev, ovf), pack(1'b1, 2'd3, P, 1'b0));
        btn = 4'h9;
        cycle();
        btn = 4'h8;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("sc_set_beats_clear", 32'(ovf), 32'd1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("sc_clear_alone", 32'(ovf), 32'd0);
        rdy = 1'b1;
        mon_en = 1'b1;
        expect_ev(2'd3, P);
        expect_ev(2'd0, L);
        wait_drain("sc_drain", 6, 1'b0);
        btn = 4'h0;
        expect_ev(2'd3, L);
        wait_drain("sc_release", 6, 1'b0);
        chk("sc_no_new_overflow", 32'(ovf), 32'd0);

        // Button 3 repeating; a new press on button 1 gets in before the next repeat.
        expect_ev(2'd3, P);
        expect_ev(2'd3, R);
        btn = 4'h8;
        wait_drain("fair_first", 40, 1'b1);
        btn = 4'hA;
        expect_ev(2'd1, P);
        expect_ev(2'd3, R);
        wait_drain("fair_order", 30, 1'b1);

        // Async reset with an event in flight discards everything.
        mon_en = 1'b0;
        rdy = 1'b0;
        btn = 4'h1;
        repeat (3) cycle();
        chk("rst_pre_valid", 32'(valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_clear", pack(valid, id, ev, ovf), pack(1'b0, 2'd0, 2'd0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy = 1'b1;
        cycle();
        chk("rst_edge1", 32'({valid, ovf}), 32'd0);
        cycle();
        chk("rst_press_id0", pack(valid, id, ev, ovf), pack(1'b1, 2'd0, P, 1'b0));
        cycle();
        chk("rst_quiet", 32'({valid, ovf}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
